// File: rtl/sift_pkg.sv
// Shared types and constants for the SIFT keypoint pipeline.
// Covers the DoG sample type, the extrema-detector FSM states and the default contrast threshold.
package sift_pkg;

    localparam int DOG_W      = 9;
    localparam int THRESH_DEF = 8;

    typedef logic signed [DOG_W-1:0] dog_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dog_line_buffer.sv
// Two-row DoG line store: one word per column packs {row y-2, row y-1}.
// The read happens before the write, so an accepted sample at column x returns the two rows above it.
module dog_line_buffer
    import sift_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  dog_t          din,
    output dog_t          row1,
    output dog_t          row2
);

    logic [2*DOG_W-1:0] mem [WIDTH];
    logic [2*DOG_W-1:0] rd;

    assign rd   = mem[addr];
    assign row1 = rd[DOG_W-1:0];
    assign row2 = rd[2*DOG_W-1:DOG_W];

    // Row y-1 ages into the y-2 slot, and the new sample becomes row y-1 for the next line.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= {row1, din};
        end
    end

endmodule

// File: rtl/dog_extrema_detect.sv
// Streaming 3x3 strict local-extremum detector on the signed DoG raster stream.
// Interior pixels that clear the contrast threshold are emitted as keypoint candidates.
module dog_extrema_detect
    import sift_pkg::*;
#(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int THRESH = THRESH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  dog_t                      dog_pixel,
    input  logic                      dog_valid,
    output logic                      kp_valid,
    output logic [$clog2(WIDTH)-1:0]  kp_x,
    output logic [$clog2(HEIGHT)-1:0] kp_y,
    output dog_t                      kp_value,
    output logic                      kp_is_max,
    output logic [15:0]               kp_count,
    output logic                      done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [DOG_W-1:0] THRESH_U = DOG_W'(THRESH);
    localparam logic [XW-1:0]    X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(HEIGHT - 1);

    function automatic logic [DOG_W-1:0] abs_mag(input dog_t v);
        return v[DOG_W-1] ? DOG_W'(-v) : DOG_W'(v);
    endfunction

    state_t        state;
    logic          flush_cnt;
    logic [XW-1:0] col, col_base;
    logic [YW-1:0] row, row_base;
    logic          accept, last_px, interior;
    dog_t          row1, row2;
    dog_t          win_p0   [3][3];
    dog_t          win_base [3][3];
    logic          vld_p0;
    logic [XW-1:0] cx_p0;
    logic [YW-1:0] cy_p0;
    logic          is_max, is_min, kp_hit;

    // A start pulse rebases the frame in the same cycle, so a coincident sample lands at (0,0).
    always_comb begin
        col_base = start ? '0 : col;
        row_base = start ? '0 : row;
        accept   = dog_valid && (start || state == ST_RUN);
        last_px  = accept && (col_base == X_LAST) && (row_base == Y_LAST);
        interior = (col_base >= XW'(2)) && (row_base >= YW'(2));
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_base[r][c] = start ? '0 : win_p0[r][c];
            end
        end
    end

    dog_line_buffer #(
        .WIDTH (WIDTH)
    ) u_line_buffer (
        .clk   (clk),
        .wr_en (accept),
        .addr  (col_base),
        .din   (dog_pixel),
        .row1  (row1),
        .row2  (row2)
    );

    // p0: window capture; column 2 is the newest column (x), centre sits at (x-1, y-1).
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_p0[r][0] <= win_base[r][1];
                win_p0[r][1] <= win_base[r][2];
            end
            win_p0[0][2] <= row2;
            win_p0[1][2] <= row1;
            win_p0[2][2] <= dog_pixel;
            cx_p0        <= col_base - 1'b1;
            cy_p0        <= row_base - 1'b1;
        end else if (start) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_p0[r][c] <= '0;
                end
            end
        end
    end

    always_comb begin
        is_max = 1'b1;
        is_min = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1)) begin
                    if (win_p0[r][c] >= win_p0[1][1]) is_max = 1'b0;
                    if (win_p0[r][c] <= win_p0[1][1]) is_min = 1'b0;
                end
            end
        end
        kp_hit = vld_p0 && (is_max || is_min) && (abs_mag(win_p0[1][1]) >= THRESH_U);
    end

    // p1: keypoint outputs, counters and frame FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            flush_cnt <= 1'b0;
            col       <= '0;
            row       <= '0;
            vld_p0    <= 1'b0;
            kp_valid  <= 1'b0;
            kp_x      <= '0;
            kp_y      <= '0;
            kp_value  <= '0;
            kp_is_max <= 1'b0;
            kp_count  <= '0;
            done      <= 1'b0;
        end else begin
            if (start) begin
                state     <= ST_RUN;
                flush_cnt <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_IDLE;
                    ST_RUN: begin
                        if (last_px) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= 1'b0;
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_cnt) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            flush_cnt <= 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_DONE;
                    default: state <= ST_IDLE;
                endcase
            end

            if (accept) begin
                col <= (col_base == X_LAST) ? '0 : col_base + 1'b1;
                if (col_base == X_LAST) begin
                    row <= (row_base == Y_LAST) ? '0 : row_base + 1'b1;
                end else begin
                    row <= row_base;
                end
            end else if (start) begin
                col <= '0;
                row <= '0;
            end

            vld_p0   <= accept && interior;
            kp_valid <= kp_hit && !start;
            if (kp_hit && !start) begin
                kp_x      <= cx_p0;
                kp_y      <= cy_p0;
                kp_value  <= win_p0[1][1];
                kp_is_max <= is_max;
            end

            if (start) begin
                kp_count <= '0;
            end else if (kp_hit && kp_count != 16'hFFFF) begin
                kp_count <= kp_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dog_extrema_detect.sv
// Randomized and directed bench for dog_extrema_detect against a whole-frame reference scan.
module tb_dog_extrema_detect;

    localparam int W  = 128;
    localparam int H  = 128;
    localparam int TH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [8:0] dog_pixel;
    logic              dog_valid;
    logic              kp_valid;
    logic [6:0]        kp_x;
    logic [6:0]        kp_y;
    logic signed [8:0] kp_value;
    logic              kp_is_max;
    logic [15:0]       kp_count;
    logic              done;

    dog_extrema_detect #(.WIDTH(W), .HEIGHT(H), .THRESH(TH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dog_pixel (dog_pixel),
        .dog_valid (dog_valid),
        .kp_valid  (kp_valid),
        .kp_x      (kp_x),
        .kp_y      (kp_y),
        .kp_value  (kp_value),
        .kp_is_max (kp_is_max),
        .kp_count  (kp_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int img     [H][W];
    int acc_cyc [H][W];
    int last_acc;
    int obs_x[$], obs_y[$], obs_v[$], obs_m[$], obs_c[$];
    int exp_x[$], exp_y[$], exp_v[$], exp_m[$];

    always @(negedge clk) begin
        if (rst && kp_valid) begin
            obs_x.push_back(int'(kp_x));
            obs_y.push_back(int'(kp_y));
            obs_v.push_back(int'(kp_value));
            obs_m.push_back(int'(kp_is_max));
            obs_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_kp_valid"}, int'(kp_valid), 0);
        chk({tag, "_kp_x"}, int'(kp_x), 0);
        chk({tag, "_kp_y"}, int'(kp_y), 0);
        chk({tag, "_kp_value"}, int'(kp_value), 0);
        chk({tag, "_kp_is_max"}, int'(kp_is_max), 0);
        chk({tag, "_kp_count"}, int'(kp_count), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    task automatic clear_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 0;
    endtask

    task automatic random_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = int'($urandom_range(80)) - 40;
    endtask

    // Reference: scan every interior centre with complete neighbourhood up to row y_last.
    task automatic build_exp(input int y_last);
        int ymax;
        exp_x.delete(); exp_y.delete(); exp_v.delete(); exp_m.delete();
        ymax = (y_last - 1 < H - 2) ? y_last - 1 : H - 2;
        for (int cy = 1; cy <= ymax; cy++) begin
            for (int cx = 1; cx <= W - 2; cx++) begin
                int v, mag;
                bit mx, mn;
                v  = img[cy][cx];
                mx = 1'b1;
                mn = 1'b1;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dy != 0 || dx != 0) begin
                            if (!(v > img[cy+dy][cx+dx])) mx = 1'b0;
                            if (!(v < img[cy+dy][cx+dx])) mn = 1'b0;
                        end
                mag = (v < 0) ? -v : v;
                if ((mx || mn) && mag >= TH) begin
                    exp_x.push_back(cx);
                    exp_y.push_back(cy);
                    exp_v.push_back(v);
                    exp_m.push_back(mx ? 1 : 0);
                end
            end
        end
    endtask

    task automatic compare_kps(input string tag);
        int n;
        chk({tag, "_num_kp"}, obs_x.size(), exp_x.size());
        n = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_x"}, obs_x[i], exp_x[i]);
            chk({tag, "_y"}, obs_y[i], exp_y[i]);
            chk({tag, "_value"}, obs_v[i], exp_v[i]);
            chk({tag, "_is_max"}, obs_m[i], exp_m[i]);
            chk({tag, "_latency"}, obs_c[i], acc_cyc[exp_y[i]+1][exp_x[i]+1] + 1);
        end
        obs_x.delete(); obs_y.delete(); obs_v.delete(); obs_m.delete(); obs_c.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_rows(input int y0, input int y1, input int gap, input bit with_start);
        for (int y = y0; y <= y1; y++) begin
            for (int x = 0; x < W; x++) begin
                while (gap > 0 && int'($urandom_range(99)) < gap) begin
                    dog_valid = 1'b0;
                    @(posedge clk); #1;
                end
                dog_valid = 1'b1;
                dog_pixel = 9'(img[y][x]);
                if (with_start && y == y0 && x == 0) start = 1'b1;
                @(posedge clk); #1;
                start         = 1'b0;
                acc_cyc[y][x] = cyc;
                last_acc      = cyc;
            end
        end
        dog_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        build_exp(H - 1);
        @(posedge clk); #1;
        chk({tag, "_done_early"}, int'(done), 0);
        @(posedge clk); #1;
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_done_delay"}, cyc - last_acc, 2);
        compare_kps(tag);
        chk({tag, "_kp_count"}, int'(kp_count), exp_x.size());
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        dog_valid = 1'b0;
        dog_pixel = '0;
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // All-zero frame
        clear_img();
        pulse_start();
        drive_rows(0, H - 1, 0, 1'b0);
        finish_frame("zero");

        // Directed: max, min, sub-threshold, border and tie cases
        clear_img();
        img[20][10]  = 50;
        img[64][64]  = -30;
        img[30][30]  = 5;
        img[5][0]    = 90;
        img[40][127] = 90;
        img[0][50]   = 90;
        img[127][50] = 90;
        img[20][20]  = 70;
        img[20][21]  = 70;
        pulse_start();
        drive_rows(0, H - 1, 0, 1'b0);
        finish_frame("directed");

        // Spike with 50% valid gaps, abandoned at row 60
        clear_img();
        img[8][10] = 77;
        pulse_start();
        drive_rows(0, 59, 50, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        build_exp(59);
        compare_kps("gaps");
        chk("gaps_kp_count", int'(kp_count), exp_x.size());

        // Restart coinciding with the first valid sample, single spike at (100,100)
        clear_img();
        img[100][100] = 120;
        drive_rows(0, H - 1, 0, 1'b1);
        finish_frame("restart");

        // Random frame with random gaps
        random_img();
        pulse_start();
        drive_rows(0, H - 1, 20, 1'b0);
        finish_frame("random");

        // Asynchronous reset mid-frame
        random_img();
        img[1][5] = 200;
        pulse_start();
        drive_rows(0, 3, 0, 1'b0);
        chk("pre_rst_count_nonzero", int'(kp_count != 16'd0), 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dog_extrema_detect.md
# dog_extrema_detect

Streaming 3x3 spatial extrema detector that consumes the raster-order signed Difference-of-Gaussian stream from the DoG stage. It flags interior pixels whose DoG magnitude clears a contrast threshold and that are strict local maxima or minima of their 8-neighbourhood. Each flagged pixel is emitted as a keypoint candidate (x, y, value, polarity) to the downstream descriptor/keypoint-collection stage. The block uses two line buffers and a 3x3 window and never stalls its input.

## Interface
- WIDTH, 128, frame width in pixels (>= 3)
- HEIGHT, 128, frame height in pixels (>= 3)
- THRESH, 8, unsigned contrast threshold; a candidate requires |value| >= THRESH (0..255)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; clears counters and window, and begins frame capture
- dog_pixel  in  9  signed DoG sample (-255..+255)
- dog_valid  in  1  dog_pixel valid this cycle; gaps allowed, no backpressure
- kp_valid  out  1  one-cycle pulse, keypoint fields valid
- kp_x  out  $clog2(WIDTH)  keypoint column
- kp_y  out  $clog2(HEIGHT)  keypoint row
- kp_value  out  9  signed DoG value at keypoint
- kp_is_max  out  1  1 = maximum, 0 = minimum
- kp_count  out  16  keypoints this frame, saturating at 16'hFFFF
- done  out  1  level; frame fully processed, cleared by start

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE to RUN on start.
  - RUN to FLUSH on acceptance of pixel (WIDTH-1, HEIGHT-1).
  - FLUSH to DONE after 2 cycles.
  - DONE to RUN on start.
  - start in any state (including RUN/FLUSH) restarts: counters, window, and pipeline valids are cleared and the state goes to RUN.
- dog_valid is ignored outside RUN.
- Column/row counters advance only on accepted samples. Column wraps WIDTH-1 to 0 and increments the row.
- Line buffers hold rows y-1 and y-2. On each accepted sample, the new column (row y-2, row y-1, current) shifts into the 3x3 window.
- The window centre is (col-1, row-1). It is evaluated only when 1 <= centre x <= WIDTH-2 and 1 <= centre y <= HEIGHT-2, so border pixels never produce keypoints.
  - When col = 0 or 1, the window contains wrapped data from the previous row. These windows are discarded by the border rule, not by clearing.
- Maximum: centre strictly greater than all 8 neighbours.
- Minimum: centre strictly less than all 8 neighbours.
- Any tie with a neighbour means no keypoint.
- Contrast: |centre| computed as 9-bit unsigned (max 255) and compared against THRESH as unsigned.
- All comparisons are 9-bit signed.
- kp_count increments with each kp_valid and holds at 16'hFFFF once saturated.

## Timing
- Reset values: kp_valid=0, kp_x=0, kp_y=0, kp_value=0, kp_is_max=0, kp_count=0, done=0, state=IDLE, counters=0.
- Latency: the sample completing a window is accepted on edge N. The window registers load on N, the comparison result registers on N+1, and kp_valid is high for the cycle after edge N+1 (2 cycles).
- Throughput: one sample per cycle, with at most one keypoint per cycle.
- done rises 2 cycles after the final sample is accepted (FLUSH drained) and stays high until start.
- kp_count is final when done rises.
- A start pulse that coincides with dog_valid restarts the frame, and that sample is accepted as pixel (0,0).
- Asserting rst mid-frame immediately returns all outputs to reset values. Line-buffer RAM contents need not be cleared.

## Structure
- Shared package sift_pkg holds:
  - DOG_W = 9
  - the signed DoG pixel typedef
  - the FSM state enum
  - the default THRESH constant
- One sub-module, dog_line_buffer: single-clock RAM of depth WIDTH and width 2x9. It reads and writes the same address each accepted sample, with a read-before-write result providing rows y-1 and y-2.
- Window, comparators, counters, and FSM live in dog_extrema_detect.

## Test plan
- All-zero 128x128 frame, THRESH=8: kp_count=0, no kp_valid, and done high 2 cycles after the last sample.
- Zero frame with +50 at (10,20): exactly one kp_valid with x=10, y=20, value=+50, kp_is_max=1, kp_count=1.
- Zero frame with -30 at (64,64), plus +5 at (30,30): one keypoint (64,64, -30, is_max=0). The +5 is rejected by the threshold.
- +90 at border pixels (0,5), (127,40), (50,0), (50,127) plus adjacent equal +70 pair at (20,20)/(21,20): no keypoints (border rule and tie rule).
- Single spike with random dog_valid gaps (50% duty): same keypoint fields as the gap-free run, and kp_valid exactly 2 cycles after the completing sample.
- start pulsed mid-frame at row 60, then a full frame with one spike at (100,100): only that keypoint is reported, kp_count=1. rst deasserted then asserted mid-frame: all outputs 0 immediately.
